ring_decoder: RTL

- Receive-side checker for the 8-bit rotating one-hot ring pattern produced by the ring counter on `uo_out`.
- Samples the ring bus, decodes the active position to a 3-bit index, verifies each step against the expected rotation and locks onto a healthy ring.
- Flags and counts sequence errors and counts completed revolutions.
- Sits next to the counter, or on another tile consuming the same 8 pins, as a self-test monitor.

---
 rtl/ring_decoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ring_decoder.sv
// Receive-side checker for an 8-bit rotating one-hot ring: decodes, verifies rotation, locks, counts.
// Optional macro RING_DECODER_DIR_DETECT_EN accepts either rotation direction and adds the `dir` output.
module ring_decoder #(
  parameter int LOCK_COUNT = 3,
  parameter int REV_W      = 8,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ring_in,
  input  logic             sample_en,
  output logic [2:0]       index,
  output logic             index_valid,
  output logic             lock,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
`ifdef RING_DECODER_DIR_DETECT_EN
  output logic             dir,
`endif
  output logic [REV_W-1:0] rev_count
);

  // The state register is the lock flag: LOCKED drives lock directly.
  typedef enum logic {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       index_q, index_d;
  logic             index_valid_q, index_valid_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [REV_W-1:0] rev_count_q, rev_count_d;
  logic [3:0]       run_q, run_d;
  logic             prev_valid_q, prev_valid_d;
  logic             dir_q, dir_d;

  logic [3:0] bit_cnt;
  logic [2:0] dec;
  logic       one_hot;
  logic [2:0] exp_dn, exp_up, exp_next;
  logic       step_ok;
  logic       step_dir;
  logic       rev_hit;

  always_comb begin
    bit_cnt = 4'd0;
    dec     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ring_in[i]) begin
        bit_cnt = bit_cnt + 4'd1;
        dec     = i[2:0];
      end
    end
    one_hot = (bit_cnt == 4'd1);
  end

  assign exp_dn   = index_q - 3'd1;
  assign exp_up   = index_q + 3'd1;
  assign exp_next = dir_q ? exp_up : exp_dn;

  // Hunting step check; with direction detect, the first step of a run may go either way.
  always_comb begin
    step_ok  = 1'b0;
    step_dir = dir_q;
    if (prev_valid_q) begin
`ifdef RING_DECODER_DIR_DETECT_EN
      if (run_q == 4'd0) begin
        step_ok  = (dec == exp_dn) || (dec == exp_up);
        step_dir = (dec == exp_up);
      end else begin
        step_ok = (dec == exp_next);
      end
`else
      step_ok = (dec == exp_next);
`endif
    end
  end

  assign rev_hit = dir_q ? (index_q == 3'd7 && dec == 3'd0)
                         : (index_q == 3'd0 && dec == 3'd7);

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    index_valid_d = 1'b0;
    err_d         = 1'b0;
    err_count_d   = err_count_q;
    rev_count_d   = rev_count_q;
    run_d         = run_q;
    prev_valid_d  = prev_valid_q;
    dir_d         = dir_q;

    if (sample_en) begin
      case (state_q)
        S_HUNT: begin
          if (one_hot) begin
            index_d       = dec;
            index_valid_d = 1'b1;
            prev_valid_d  = 1'b1;
            if (step_ok) begin
              dir_d = step_dir;
              if (run_q + 4'd1 == 4'(LOCK_COUNT)) begin
                state_d = S_LOCKED;
                run_d   = 4'd0;
              end else begin
                run_d = run_q + 4'd1;
              end
            end else begin
              run_d = 4'd0;
              dir_d = 1'b0;
            end
          end else begin
            run_d        = 4'd0;
            prev_valid_d = 1'b0;
            dir_d        = 1'b0;
          end
        end
        default: begin
          if (one_hot && dec == exp_next) begin
            index_d       = dec;
            index_valid_d = 1'b1;
            if (rev_hit) rev_count_d = rev_count_q + 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
            run_d   = 4'd0;
            dir_d   = 1'b0;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (one_hot) begin
              index_d       = dec;
              index_valid_d = 1'b1;
              prev_valid_d  = 1'b1;
            end else begin
              prev_valid_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      index_q       <= 3'd0;
      index_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      rev_count_q   <= '0;
      run_q         <= 4'd0;
      prev_valid_q  <= 1'b0;
      dir_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      rev_count_q   <= rev_count_d;
      run_q         <= run_d;
      prev_valid_q  <= prev_valid_d;
      dir_q         <= dir_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign lock        = (state_q == S_LOCKED);
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign rev_count   = rev_count_q;
`ifdef RING_DECODER_DIR_DETECT_EN
  assign dir         = dir_q;
`endif

endmodule
